// File: rtl/aes_ks_pkg.sv
// Shared AES key-schedule definitions: FSM encoding, S-box table, GF(2^8) xtime
// and key-size helpers. Used by aes_key_schedule and aes_subword.
package aes_ks_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2,
        READY  = 2'd3
    } ks_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic int nw_of(input int key_bits);
        return 4 * (nr_of(key_bits) + 1);
    endfunction

endpackage

// File: rtl/aes_subword.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
// Shared by the key schedule and the round engine.
module aes_subword
    import aes_ks_pkg::*;
(
    input  logic [31:0] data,
    output logic [31:0] result
);

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign result[8*b +: 8] = SBOX[data[8*b +: 8]];
    end

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128/192/256 key expander, one schedule word per cycle, with a
// registered round-key read port. Optional zeroize port under AES_KS_ZEROIZE_EN.
//
// state  | meaning
// IDLE   | no schedule held, waiting for start
// LOAD   | copy captured key into w[0..NK-1]
// EXPAND | generate w[NK..NW-1], one word per cycle
// READY  | schedule complete and readable
module aes_key_schedule
    import aes_ks_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
`ifdef AES_KS_ZEROIZE_EN
    input  logic                zeroize,
`endif
    output logic                busy,
    output logic                keys_valid,
    input  logic [3:0]          rk_idx,
    output logic [127:0]        rk_out
);

    localparam int NK = nk_of(KEY_BITS);
    localparam int NR = nr_of(KEY_BITS);
    localparam int NW = nw_of(KEY_BITS);
    localparam int CW = $clog2(NW + 1);
    localparam int PW = $clog2(NK);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
    end

    ks_state_t           state, state_nxt;
    logic [KEY_BITS-1:0] key_q;
    logic [31:0]         w [NW];
    logic [CW-1:0]       cnt;
    logic [PW-1:0]       ph;
    logic [7:0]          rcon;
    logic [31:0]         prev, sub_in, sub_out, temp;
    logic                zero_req, start_ok;

`ifdef AES_KS_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    assign busy       = (state == LOAD) || (state == EXPAND);
    assign keys_valid = (state == READY);
    assign start_ok   = start && ((state == IDLE) || (state == READY));

    // ph tracks i mod NK alongside cnt so no divider is needed
    assign prev   = w[cnt - CW'(1)];
    assign sub_in = (ph == '0) ? {prev[23:0], prev[31:24]} : prev;

    aes_subword u_subword (
        .data   (sub_in),
        .result (sub_out)
    );

    always_comb begin
        temp = prev;
        if (ph == '0) begin
            temp = sub_out ^ {rcon, 24'h0};
        end else if (NK == 8 && ph == PW'(4)) begin
            temp = sub_out;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = EXPAND;
            EXPAND:  if (cnt == CW'(NW - 1)) state_nxt = READY;
            READY:   if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
        if (zero_req) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q  <= '0;
            cnt    <= '0;
            ph     <= '0;
            rcon   <= 8'h01;
            rk_out <= '0;
            for (int j = 0; j < NW; j++) w[j] <= '0;
        end else if (zero_req) begin
            key_q  <= '0;
            cnt    <= '0;
            ph     <= '0;
            rcon   <= 8'h01;
            rk_out <= '0;
            for (int j = 0; j < NW; j++) w[j] <= '0;
        end else begin
            if (start_ok) key_q <= key_in;
            case (state)
                LOAD: begin
                    for (int j = 0; j < NK; j++) w[j] <= key_q[KEY_BITS-1-32*j -: 32];
                    cnt  <= CW'(NK);
                    ph   <= '0;
                    rcon <= 8'h01;
                end
                EXPAND: begin
                    w[cnt] <= w[cnt - CW'(NK)] ^ temp;
                    cnt    <= cnt + 1'b1;
                    ph     <= (ph == PW'(NK - 1)) ? '0 : ph + 1'b1;
                    if (ph == '0) rcon <= xtime(rcon);
                end
                default: ;
            endcase
            if (keys_valid && rk_idx <= 4'(NR)) begin
                rk_out <= {w[{rk_idx, 2'b00}], w[{rk_idx, 2'b01}],
                           w[{rk_idx, 2'b10}], w[{rk_idx, 2'b11}]};
            end else begin
                rk_out <= '0;
            end
        end
    end

endmodule
